// File: rtl/fu_dispatch_scheduler.sv
// Round-robin dispatcher that shares one integer functional unit among the
// reservation-station slots and broadcasts each result on the CDB (valid/ready).
module fu_dispatch_scheduler #(
    parameter int NUM_RS  = 4,
    parameter int TAG_W   = 3,
    parameter int TIMEOUT = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_RS-1:0]       rs_req,
    input  logic [NUM_RS*16-1:0]    rs_instr,
    input  logic [NUM_RS*TAG_W-1:0] rs_tag,
    input  logic [NUM_RS*16-1:0]    rs_vj,
    input  logic [NUM_RS*16-1:0]    rs_vk,
    output logic [NUM_RS-1:0]       rs_grant,
    input  logic                    fu_available,
    output logic                    fu_issue,
    output logic [15:0]             fu_instruction,
    output logic [TAG_W-1:0]        fu_tag,
    output logic [15:0]             fu_r1,
    output logic [15:0]             fu_r2,
    input  logic                    fu_done,
    input  logic [15:0]             fu_result,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [15:0]             cdb_data,
    input  logic                    cdb_ready,
    output logic                    busy,
    output logic                    err_opcode,
    output logic                    err_timeout
);

    localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_BCAST = 2'd3
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_RS-1:0]  rs_grant_q;
    logic               fu_issue_q;
    logic               cdb_valid_q;
    logic               err_opcode_q;
    logic               err_timeout_q;
    logic [15:0]        instr_q;
    logic [TAG_W-1:0]   tag_q;
    logic [15:0]        vj_q;
    logic [15:0]        vk_q;
    logic [TAG_W-1:0]   cdb_tag_q;
    logic [15:0]        cdb_data_q;

    logic [15:0]        slot_instr [NUM_RS];
    logic [TAG_W-1:0]   slot_tag   [NUM_RS];
    logic [15:0]        slot_vj    [NUM_RS];
    logic [15:0]        slot_vk    [NUM_RS];

    logic               sel_found;
    logic [PTR_W-1:0]   sel_idx;
    logic [NUM_RS-1:0]  sel_onehot;
    logic [PTR_W-1:0]   rr_ptr_d;
    logic [3:0]         sel_op;
    logic               sel_legal;

    for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_slot
        assign slot_instr[gi] = rs_instr[16*gi +: 16];
        assign slot_tag[gi]   = rs_tag[TAG_W*gi +: TAG_W];
        assign slot_vj[gi]    = rs_vj[16*gi +: 16];
        assign slot_vk[gi]    = rs_vk[16*gi +: 16];
        assign sel_onehot[gi] = (sel_idx == PTR_W'(gi));
    end

    // First requester at or after rr_ptr, wrapping modulo NUM_RS.
    always_comb begin
        int cand;
        cand      = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_RS) begin
                cand = cand - NUM_RS;
            end
            if (!sel_found && rs_req[cand[PTR_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign rr_ptr_d  = (sel_idx == PTR_W'(NUM_RS - 1)) ? '0 : sel_idx + PTR_W'(1);
    assign sel_op    = slot_instr[sel_idx][3:0];
    assign sel_legal = (sel_op == 4'h0) || (sel_op == 4'h1) ||
                       (sel_op == 4'h4) || (sel_op == 4'h5);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
            rs_grant_q    <= '0;
            fu_issue_q    <= 1'b0;
            cdb_valid_q   <= 1'b0;
            err_opcode_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            instr_q       <= '0;
            tag_q         <= '0;
            vj_q          <= '0;
            vk_q          <= '0;
            cdb_tag_q     <= '0;
            cdb_data_q    <= '0;
        end else begin
            rs_grant_q    <= '0;
            fu_issue_q    <= 1'b0;
            err_opcode_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sel_found && fu_available) begin
                        instr_q    <= slot_instr[sel_idx];
                        tag_q      <= slot_tag[sel_idx];
                        vj_q       <= slot_vj[sel_idx];
                        vk_q       <= slot_vk[sel_idx];
                        rr_ptr_q   <= rr_ptr_d;
                        rs_grant_q <= sel_onehot;
                        // Illegal opcodes are consumed and dropped without touching the FU.
                        if (sel_legal) begin
                            fu_issue_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end else begin
                            err_opcode_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (fu_done) begin
                        cdb_data_q  <= fu_result;
                        cdb_tag_q   <= tag_q;
                        cdb_valid_q <= 1'b1;
                        state_q     <= S_BCAST;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_BCAST: begin
                    if (cdb_ready) begin
                        cdb_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rs_grant       = rs_grant_q;
    assign fu_issue       = fu_issue_q;
    assign fu_instruction = instr_q;
    assign fu_tag         = tag_q;
    assign fu_r1          = vj_q;
    assign fu_r2          = vk_q;
    assign cdb_valid      = cdb_valid_q;
    assign cdb_tag        = cdb_tag_q;
    assign cdb_data       = cdb_data_q;
    assign busy           = (state_q != S_IDLE);
    assign err_opcode     = err_opcode_q;
    assign err_timeout    = err_timeout_q;

endmodule

// File: tb/tb_fu_dispatch_scheduler.sv
// Directed bench for fu_dispatch_scheduler: transaction-level reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_fu_dispatch_scheduler;

    localparam int NRS = 4;
    localparam int TW  = 3;
    localparam int TMO = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NRS-1:0]    rs_req = '0;
    logic [15:0]       s_instr [NRS];
    logic [TW-1:0]     s_tag   [NRS];
    logic [15:0]       s_vj    [NRS];
    logic [15:0]       s_vk    [NRS];
    logic [NRS*16-1:0] rs_instr, rs_vj, rs_vk;
    logic [NRS*TW-1:0] rs_tag;
    logic [NRS-1:0]    rs_grant;
    logic              fu_available = 1'b1;
    logic              fu_issue;
    logic [15:0]       fu_instruction, fu_r1, fu_r2;
    logic [TW-1:0]     fu_tag;
    logic              fu_done = 1'b0;
    logic [15:0]       fu_result = '0;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [15:0]       cdb_data;
    logic              cdb_ready = 1'b0;
    logic              busy, err_opcode, err_timeout;

    assign rs_instr = {s_instr[3], s_instr[2], s_instr[1], s_instr[0]};
    assign rs_tag   = {s_tag[3], s_tag[2], s_tag[1], s_tag[0]};
    assign rs_vj    = {s_vj[3], s_vj[2], s_vj[1], s_vj[0]};
    assign rs_vk    = {s_vk[3], s_vk[2], s_vk[1], s_vk[0]};

    fu_dispatch_scheduler #(.NUM_RS(NRS), .TAG_W(TW), .TIMEOUT(TMO)) dut (
        .clock          (clock),
        .reset          (reset),
        .rs_req         (rs_req),
        .rs_instr       (rs_instr),
        .rs_tag         (rs_tag),
        .rs_vj          (rs_vj),
        .rs_vk          (rs_vk),
        .rs_grant       (rs_grant),
        .fu_available   (fu_available),
        .fu_issue       (fu_issue),
        .fu_instruction (fu_instruction),
        .fu_tag         (fu_tag),
        .fu_r1          (fu_r1),
        .fu_r2          (fu_r2),
        .fu_done        (fu_done),
        .fu_result      (fu_result),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_ready      (cdb_ready),
        .busy           (busy),
        .err_opcode     (err_opcode),
        .err_timeout    (err_timeout)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NRS-1:0] req, input int ptr);
        for (int k = 0; k < NRS; k++) begin
            if (req[(ptr + k) % NRS]) return (ptr + k) % NRS;
        end
        return 0;
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return (op == 4'h0) || (op == 4'h1) || (op == 4'h4) || (op == 4'h5);
    endfunction

    function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h4:    return 16'(a * b);
            4'h5:    return (b == 16'd0) ? 16'hFFFF : a / b;
            default: return 16'd0;
        endcase
    endfunction

    // Reference model: a job is either absent, counting cycles since its issue, or broadcasting.
    int              m_ptr = 0;
    int              m_age = 0;
    bit              m_active = 1'b0;
    bit              m_bcast = 1'b0;
    int              m_pick;
    logic [NRS-1:0]  exp_grant = '0;
    logic            exp_issue = 1'b0, exp_busy = 1'b0, exp_cdb_valid = 1'b0;
    logic            exp_err_op = 1'b0, exp_err_to = 1'b0;
    logic [15:0]     exp_instr = '0, exp_r1 = '0, exp_r2 = '0, exp_cdb_data = '0;
    logic [TW-1:0]   exp_tag = '0, exp_cdb_tag = '0;

    assign m_pick = rr_pick(rs_req, m_ptr);

    always @(posedge clock) begin
        if (reset) begin
            m_ptr <= 0; m_age <= 0; m_active <= 1'b0; m_bcast <= 1'b0;
            exp_grant <= '0; exp_issue <= 1'b0; exp_busy <= 1'b0; exp_cdb_valid <= 1'b0;
            exp_err_op <= 1'b0; exp_err_to <= 1'b0;
            exp_instr <= '0; exp_r1 <= '0; exp_r2 <= '0; exp_tag <= '0;
            exp_cdb_tag <= '0; exp_cdb_data <= '0;
        end else begin
            exp_grant <= '0; exp_issue <= 1'b0; exp_err_op <= 1'b0; exp_err_to <= 1'b0;
            if (!m_active) begin
                if (fu_available && rs_req != '0) begin
                    exp_grant <= NRS'(1 << m_pick);
                    exp_instr <= rs_instr[16*m_pick +: 16];
                    exp_tag   <= rs_tag[TW*m_pick +: TW];
                    exp_r1    <= rs_vj[16*m_pick +: 16];
                    exp_r2    <= rs_vk[16*m_pick +: 16];
                    m_ptr     <= (m_pick + 1) % NRS;
                    if (is_legal(rs_instr[16*m_pick +: 4])) begin
                        m_active <= 1'b1; m_age <= 0; exp_issue <= 1'b1; exp_busy <= 1'b1;
                    end else begin
                        exp_err_op <= 1'b1;
                    end
                end
            end else if (m_bcast) begin
                if (cdb_ready) begin
                    m_active <= 1'b0; m_bcast <= 1'b0; exp_cdb_valid <= 1'b0; exp_busy <= 1'b0;
                end
            end else begin
                if (m_age >= 1 && fu_done) begin
                    exp_cdb_tag <= exp_tag; exp_cdb_data <= fu_result;
                    exp_cdb_valid <= 1'b1; m_bcast <= 1'b1;
                end else if (m_age >= TMO) begin
                    exp_err_to <= 1'b1; m_active <= 1'b0; exp_busy <= 1'b0;
                end
                m_age <= m_age + 1;
            end
        end
    end

    always @(negedge clock) begin
        check("grant", 32'(rs_grant), 32'(exp_grant));
        check("fu_issue", 32'(fu_issue), 32'(exp_issue));
        check("busy", 32'(busy), 32'(exp_busy));
        check("cdb_valid", 32'(cdb_valid), 32'(exp_cdb_valid));
        check("err_opcode", 32'(err_opcode), 32'(exp_err_op));
        check("err_timeout", 32'(err_timeout), 32'(exp_err_to));
        if (exp_issue) begin
            check("fu_instruction", 32'(fu_instruction), 32'(exp_instr));
            check("fu_tag", 32'(fu_tag), 32'(exp_tag));
            check("fu_r1", 32'(fu_r1), 32'(exp_r1));
            check("fu_r2", 32'(fu_r2), 32'(exp_r2));
        end
        if (exp_cdb_valid) begin
            check("cdb_tag", 32'(cdb_tag), 32'(exp_cdb_tag));
            check("cdb_data", 32'(cdb_data), 32'(exp_cdb_data));
        end
    end

    // Environment: RS array drops consumed requests, FU answers after its latency, CDB sink.
    bit             hold_req = 1'b0;
    bit             fu_hang = 1'b0;
    int             ready_after = 1;
    int             valid_run = 0, last_run = 0, bcasts = 0;
    int             fu_cd = 0;
    int             err_to_cycle = -1;
    logic [15:0]    fu_pend = '0, last_data = '0;
    logic [TW-1:0]  last_tag = '0;
    logic [NRS-1:0] grants [$];
    int             issues [$];
    logic [NRS-1:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (rs_grant != '0) begin
            grants.push_back(rs_grant);
            $display("[TB] cycle %0d grant %b issue %0d err_opcode %0d", cyc, rs_grant, fu_issue, err_opcode);
            if (!hold_req) rs_req = rs_req & ~rs_grant;
        end
        if (fu_issue) issues.push_back(cyc);
        if (err_timeout) begin
            err_to_cycle = cyc;
            $display("[TB] cycle %0d wait aborted", cyc);
        end
        if (cdb_valid) begin
            valid_run++;
            if (valid_run == 1) begin
                bcasts++;
                $display("[TB] cycle %0d broadcast tag %0d data %0d", cyc, cdb_tag, cdb_data);
            end
            last_tag  = cdb_tag;
            last_data = cdb_data;
        end else begin
            if (valid_run > 0) last_run = valid_run;
            valid_run = 0;
        end
        cdb_ready = (valid_run >= ready_after);
        fu_done = 1'b0;
        if (fu_cd > 0) begin
            fu_cd--;
            if (fu_cd == 0) begin
                fu_done   = 1'b1;
                fu_result = fu_pend;
            end
        end
        if (fu_issue && !fu_hang) begin
            fu_cd   = (fu_instruction[3:0] == 4'h4 || fu_instruction[3:0] == 4'h5) ? 2 : 1;
            fu_pend = alu(fu_instruction[3:0], fu_r1, fu_r2);
        end
    endtask

    task automatic wait_quiet(input int max_cycles);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((rs_req != '0 || busy) && n < max_cycles);
        if (rs_req != '0 || busy) begin
            tests++;
            fails++;
            $display("FAIL wait_quiet: still busy after %0d cycles (req %b busy %0d)", n, rs_req, busy);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fu_cd = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, n, i0;
        for (int i = 0; i < NRS; i++) begin
            s_instr[i] = '0; s_tag[i] = '0; s_vj[i] = '0; s_vk[i] = '0;
        end
        repeat (3) tick();
        check("rst_grant", 32'(rs_grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cdb_valid", 32'(cdb_valid), 32'h0);
        check("rst_fu_issue", 32'(fu_issue), 32'h0);
        check("rst_cdb_data", 32'(cdb_data), 32'h0);
        reset = 1'b0;

        // Single ADD through the whole pipeline.
        s_instr[0] = 16'h0A10; s_vj[0] = 16'd5; s_vk[0] = 16'd7; s_tag[0] = 3'd3;
        rs_req = 4'b0001;
        tick();
        check("t1_issue", 32'(fu_issue), 32'h1);
        check("t1_grant", 32'(rs_grant), 32'h1);
        check("t1_r1", 32'(fu_r1), 32'd5);
        check("t1_r2", 32'(fu_r2), 32'd7);
        check("t1_tag", 32'(fu_tag), 32'd3);
        tick();
        tick();
        check("t1_cdb_valid", 32'(cdb_valid), 32'h1);
        check("t1_cdb_tag", 32'(cdb_tag), 32'd3);
        check("t1_cdb_data", 32'(cdb_data), 32'd12);
        tick();
        check("t1_busy_after", 32'(busy), 32'h0);
        check("t1_valid_after", 32'(cdb_valid), 32'h0);

        // Round-robin fairness with all slots requesting continuously.
        do_reset();
        for (int i = 0; i < NRS; i++) begin
            s_instr[i] = 16'h0000; s_vj[i] = 16'(10 * i + 1); s_vk[i] = 16'd2; s_tag[i] = TW'(i);
        end
        grants.delete(); issues.delete();
        hold_req = 1'b1;
        rs_req = 4'b1111;
        n = 0;
        while (grants.size() < 5 && n < 200) begin
            tick();
            n++;
        end
        rs_req = '0;
        hold_req = 1'b0;
        check("t2_grant_count", 32'(grants.size()), 32'd5);
        if (grants.size() >= 5) begin
            for (int k = 0; k < 5; k++) check("t2_grant_order", 32'(grants[k]), 32'(exp_seq[k]));
        end
        if (issues.size() >= 2) check("t2_issue_spacing", 32'(issues[1] - issues[0]), 32'd4);
        wait_quiet(50);

        // MUL with a stalled CDB: broadcast must stay stable for four cycles.
        s_instr[2] = 16'h0004; s_vj[2] = 16'd6; s_vk[2] = 16'd7; s_tag[2] = 3'd5;
        ready_after = 4;
        b0 = bcasts;
        rs_req = 4'b0100;
        n = 0;
        do begin
            tick();
            n++;
            if (cdb_valid) begin
                check("t3_cdb_tag", 32'(cdb_tag), 32'd5);
                check("t3_cdb_data", 32'(cdb_data), 32'd42);
            end
        end while ((busy || rs_req != '0) && n < 40);
        ready_after = 1;
        check("t3_bcast_count", 32'(bcasts - b0), 32'd1);
        check("t3_valid_cycles", 32'(last_run), 32'd4);

        // Illegal opcode is consumed without an issue; pointer moves past it.
        s_instr[1] = 16'h0003;
        i0 = issues.size();
        rs_req = 4'b0010;
        tick();
        check("t4_grant", 32'(rs_grant), 32'b0010);
        check("t4_err_opcode", 32'(err_opcode), 32'h1);
        check("t4_no_issue", 32'(fu_issue), 32'h0);
        check("t4_idle", 32'(busy), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_still_idle", 32'(busy), 32'h0);
            check("t4_err_once", 32'(err_opcode), 32'h0);
        end
        check("t4_issue_count", 32'(issues.size() - i0), 32'd0);
        s_instr[0] = 16'h0001; s_vj[0] = 16'd50; s_vk[0] = 16'd8; s_tag[0] = 3'd1;
        s_instr[2] = 16'h0000; s_vj[2] = 16'd1;  s_vk[2] = 16'd1; s_tag[2] = 3'd2;
        grants.delete();
        rs_req = 4'b0101;
        wait_quiet(60);
        check("t4_next_count", 32'(grants.size()), 32'd2);
        if (grants.size() >= 2) begin
            check("t4_next_first", 32'(grants[0]), 32'b0100);
            check("t4_next_second", 32'(grants[1]), 32'b0001);
        end

        // FU unavailable blocks selection; then an FU that never answers times out.
        fu_hang = 1'b1;
        fu_available = 1'b0;
        s_instr[0] = 16'h0000; s_vj[0] = 16'd9; s_vk[0] = 16'd9; s_tag[0] = 3'd4;
        b0 = bcasts;
        issues.delete();
        err_to_cycle = -1;
        rs_req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_blocked_grant", 32'(rs_grant), 32'h0);
        end
        fu_available = 1'b1;
        wait_quiet(40);
        check("t5_issue_count", 32'(issues.size()), 32'd1);
        if (issues.size() >= 1) check("t5_timeout_delay", 32'(err_to_cycle - issues[0]), 32'd9);
        check("t5_no_bcast", 32'(bcasts - b0), 32'd0);
        fu_hang = 1'b0;
        s_instr[3] = 16'h0000; s_vj[3] = 16'd100; s_vk[3] = 16'd23; s_tag[3] = 3'd6;
        rs_req = 4'b1000;
        wait_quiet(40);
        check("t5_next_bcast", 32'(bcasts - b0), 32'd1);
        check("t5_next_tag", 32'(last_tag), 32'd6);
        check("t5_next_data", 32'(last_data), 32'd123);

        // Reset while waiting for a MUL; the late done must not broadcast.
        s_instr[2] = 16'h0004; s_vj[2] = 16'd3; s_vk[2] = 16'd4; s_tag[2] = 3'd2;
        b0 = bcasts;
        rs_req = 4'b0100;
        tick();
        check("t6_issue", 32'(fu_issue), 32'h1);
        tick();
        check("t6_waiting", 32'(busy), 32'h1);
        reset = 1'b1;
        tick();
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_grant", 32'(rs_grant), 32'h0);
        check("t6_rst_cdb_valid", 32'(cdb_valid), 32'h0);
        check("t6_rst_fu_instr", 32'(fu_instruction), 32'h0);
        check("t6_rst_fu_r1", 32'(fu_r1), 32'h0);
        check("t6_rst_cdb_data", 32'(cdb_data), 32'h0);
        reset = 1'b0;
        tick();
        tick();
        check("t6_post_busy", 32'(busy), 32'h0);
        check("t6_post_valid", 32'(cdb_valid), 32'h0);
        check("t6_no_bcast", 32'(bcasts - b0), 32'd0);
        s_instr[1] = 16'h0000; s_vj[1] = 16'd2; s_vk[1] = 16'd2; s_tag[1] = 3'd1;
        s_instr[3] = 16'h0000; s_vj[3] = 16'd4; s_vk[3] = 16'd4; s_tag[3] = 3'd7;
        grants.delete();
        rs_req = 4'b1010;
        wait_quiet(60);
        check("t6_next_count", 32'(grants.size()), 32'd2);
        if (grants.size() >= 2) begin
            check("t6_ptr_first", 32'(grants[0]), 32'b0010);
            check("t6_ptr_second", 32'(grants[1]), 32'b1000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
